apb_master_bridge_ms: RTL and testbench

APB_MASTER_BRIDGE_MS -- requirements
Module: apb_master_bridge_ms

---
 rtl/apb_master_bridge_ms.sv | 166 ++++++++++++++++
 tb/tb_apb_master_bridge_ms.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge_ms.sv
// APB master bridge: turns a single-strobe user request into an APB SETUP/ACCESS
// transfer to one of NSLV slaves, with address-decode error and wait timeout.
module apb_master_bridge_ms #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int NSLV    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 transfer,
  input  logic                 READ_WRITE,
  input  logic [AW-1:0]        apb_write_paddr,
  input  logic [DW-1:0]        apb_write_data,
  input  logic [AW-1:0]        apb_read_paddr,
  output logic [DW-1:0]        apb_read_data_out,
  output logic                 PSLVERR,
  output logic                 xfer_done,
  output logic                 busy,
  output logic [NSLV-1:0]      m_psel,
  output logic                 m_penable,
  output logic                 m_pwrite,
  output logic [AW-1:0]        m_paddr,
  output logic [DW-1:0]        m_pwdata,
  input  logic [NSLV*DW-1:0]   m_prdata,
  input  logic [NSLV-1:0]      m_pready,
  input  logic [NSLV-1:0]      m_pslverr
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;
  state_t state, state_nx;

  logic            rd_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   wait_cnt;
  logic [AW-1:0]   acc_addr;
  logic [IW-1:0]   acc_idx;
  logic            acc_ok;
  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;
  logic            to_hit;

  logic [NSLV-1:0] psel_d;
  logic            penable_d;
  logic            busy_d;
  logic            done_d;
  logic            err_d;
  logic [DW-1:0]   rdata_d;

  function automatic logic [NSLV-1:0] onehot(input logic [IW-1:0] i);
    logic [NSLV-1:0] r;
    r = '0;
    for (int k = 0; k < NSLV; k++)
      if (i == IW'(k)) r[k] = 1'b1;
    return r;
  endfunction

  assign acc_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;

  // Slave index lives in the top address bits; a single slave is always index 0.
  generate
    if (NSLV > 1) begin : g_idx
      assign acc_idx = acc_addr[AW-1 -: IW];
    end else begin : g_idx1
      assign acc_idx = '0;
    end
  endgenerate

  assign acc_ok = (32'(acc_idx) < NSLV);

  // Only the addressed slave's ready/error/data are looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == IW'(k)) begin
        sel_ready = m_pready[k];
        sel_err   = m_pslverr[k];
        sel_rdata = m_prdata[k*DW +: DW];
      end
    end
  end

  assign to_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state             <= IDLE;
      rd_q              <= 1'b0;
      idx_q             <= '0;
      wait_cnt          <= '0;
      m_psel            <= '0;
      m_penable         <= 1'b0;
      m_pwrite          <= 1'b0;
      m_paddr           <= '0;
      m_pwdata          <= '0;
      apb_read_data_out <= '0;
      PSLVERR           <= 1'b0;
      xfer_done         <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_nx;
      m_psel            <= psel_d;
      m_penable         <= penable_d;
      busy              <= busy_d;
      xfer_done         <= done_d;
      PSLVERR           <= err_d;
      apb_read_data_out <= rdata_d;
      if (state == IDLE && transfer) begin
        rd_q     <= READ_WRITE;
        idx_q    <= acc_idx;
        m_paddr  <= acc_addr;
        m_pwrite <= ~READ_WRITE;
        m_pwdata <= apb_write_data;
      end
      if (state_nx == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !sel_ready && !to_hit)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (transfer) state_nx = acc_ok ? SETUP : DECERR;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (sel_ready || to_hit) state_nx = IDLE;
      DECERR:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; status holds between completions.
  always_comb begin
    psel_d    = '0;
    penable_d = 1'b0;
    busy_d    = (state_nx != IDLE);
    done_d    = 1'b0;
    err_d     = PSLVERR;
    rdata_d   = apb_read_data_out;
    case (state_nx)
      SETUP:   psel_d = onehot(acc_idx);
      ACCESS: begin
        psel_d    = m_psel;
        penable_d = 1'b1;
      end
      default: ;
    endcase
    if (state == ACCESS && sel_ready) begin
      done_d = 1'b1;
      err_d  = sel_err;
      if (rd_q) rdata_d = sel_err ? '0 : sel_rdata;
    end else if ((state == ACCESS && to_hit) || state == DECERR) begin
      done_d = 1'b1;
      err_d  = 1'b1;
      if (rd_q) rdata_d = '0;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge_ms.sv
// Bench for apb_master_bridge_ms: random transfers against a latency/result model,
// a responding slave model that checks bus phases, and a completion scoreboard.
module tb_apb_master_bridge_ms;

  localparam int AW = 9, DW = 8, NSLV = 2, TIMEOUT = 4;
  localparam int EW = 25;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic transfer = 1'b0;
  logic READ_WRITE = 1'b0;
  logic [AW-1:0] apb_write_paddr = '0;
  logic [DW-1:0] apb_write_data = '0;
  logic [AW-1:0] apb_read_paddr = '0;
  logic [DW-1:0] apb_read_data_out;
  logic PSLVERR, xfer_done, busy;
  logic [NSLV-1:0] m_psel;
  logic m_penable, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [NSLV*DW-1:0] m_prdata = '0;
  logic [NSLV-1:0] m_pready = '0;
  logic [NSLV-1:0] m_pslverr = '0;

  apb_master_bridge_ms #(.AW(AW), .DW(DW), .NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
    .PSLVERR(PSLVERR), .xfer_done(xfer_done), .busy(busy),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model state ----------------
  typedef struct packed {
    logic [NSLV-1:0] psel;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [31:0]     wt;
    logic [DW-1:0]   rdata;
    logic            err;
  } slv_t;

  logic [EW-1:0] exp_q[$];   // {done cycle[15:0], pslverr, read data}
  slv_t          slv_q[$];
  logic [DW-1:0] last_rd = '0;
  int ready_cyc = 0;
  int busy_lo = 1;
  int busy_hi = 0;

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int wt, input logic [DW-1:0] srd, input logic serr);
    slv_t s;
    int a, done;
    logic e;
    logic [DW-1:0] r;
    // While the bridge is busy, request inputs are noise it must ignore.
    while (cyc < ready_cyc) begin
      transfer        = 1'($urandom);
      READ_WRITE      = 1'($urandom);
      apb_write_paddr = AW'($urandom);
      apb_read_paddr  = AW'($urandom);
      apb_write_data  = DW'($urandom);
      @(negedge PCLK);
    end
    transfer        = 1'b1;
    READ_WRITE      = rd;
    apb_write_paddr = rd ? AW'($urandom) : addr;
    apb_read_paddr  = rd ? addr : AW'($urandom);
    apb_write_data  = wd;
    a = cyc + 1;
    if (wt >= TIMEOUT) begin
      e = 1'b1;
      done = a + 1 + TIMEOUT;
    end else begin
      e = serr;
      done = a + 2 + wt;
    end
    r = rd ? (e ? '0 : srd) : last_rd;
    last_rd = r;
    s.psel   = addr[AW-1] ? 2'b10 : 2'b01;
    s.paddr  = addr;
    s.pwrite = ~rd;
    s.pwdata = wd;
    s.wt     = 32'(wt);
    s.rdata  = srd;
    s.err    = serr;
    slv_q.push_back(s);
    exp_q.push_back({16'(done), e, r});
    busy_lo   = a;
    busy_hi   = done - 1;
    ready_cyc = done;
    @(negedge PCLK);
    transfer = 1'b0;
  endtask

  task automatic idle(input int n);
    transfer = 1'b0;
    repeat (n) @(negedge PCLK);
    if (ready_cyc < cyc) ready_cyc = cyc;
  endtask

  function automatic logic [31:0] all_outputs();
    return {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, apb_read_data_out,
            PSLVERR, xfer_done, busy};
  endfunction

  // ---------------- slave model ----------------
  slv_t cur;
  logic have_cur = 1'b0;
  int acc_cnt = 0;
  logic k;

  always @(negedge PCLK) begin
    m_pready  = NSLV'($urandom);
    m_pslverr = NSLV'($urandom);
    m_prdata  = (NSLV*DW)'($urandom);
    if (PRESETn && m_psel != '0) begin
      if (!m_penable) begin
        if (slv_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_setup: psel=0x%0h with no issued request (cycle %0d)", m_psel, cyc);
          have_cur = 1'b0;
        end else begin
          cur = slv_q.pop_front();
          have_cur = 1'b1;
          acc_cnt = 0;
          check("setup_psel", m_psel, cur.psel);
          check("setup_paddr", m_paddr, cur.paddr);
          check("setup_pwrite", m_pwrite, cur.pwrite);
          check("setup_pwdata", m_pwdata, cur.pwdata);
        end
      end else if (have_cur) begin
        check("access_hold", {m_psel, m_paddr, m_pwrite, m_pwdata},
              {cur.psel, cur.paddr, cur.pwrite, cur.pwdata});
        k = cur.paddr[AW-1];
        if (acc_cnt >= int'(cur.wt)) begin
          m_pready[k]  = 1'b1;
          m_pslverr[k] = cur.err;
          if (k) m_prdata[DW +: DW] = cur.rdata;
          else   m_prdata[0 +: DW]  = cur.rdata;
        end else begin
          m_pready[k] = 1'b0;
        end
        acc_cnt++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] e_mon;

  always @(negedge PCLK) begin
    if (PRESETn) begin
      check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (xfer_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: xfer_done=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          e_mon = exp_q.pop_front();
          check("done_cycle", cyc, e_mon[24:9]);
          check("pslverr", PSLVERR, e_mon[8]);
          check("read_data", apb_read_data_out, e_mon[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    PRESETn  = 1'b0;
    transfer = 1'b1;
    repeat (3) @(negedge PCLK);
    check("reset_outputs", all_outputs(), 32'h0);
    PRESETn  = 1'b1;
    transfer = 1'b0;
    ready_cyc = cyc;
    idle(1);

    issue(1'b0, 9'h045, 8'hA5, 0, DW'($urandom), 1'b0);   // plain write, slave 0
    idle(2);
    issue(1'b1, 9'h1F0, 8'h00, 2, 8'h3C, 1'b0);           // read slave 1, two waits
    idle(1);
    issue(1'b1, 9'h0A0, 8'h00, 0, 8'h77, 1'b1);           // slave error on read
    idle(1);
    issue(1'b0, 9'h010, 8'h5A, 15, 8'h00, 1'b0);          // timeout
    idle(3);

    // Abort mid-ACCESS with a reset pulse while a request is presented.
    issue(1'b1, 9'h1C3, 8'h00, 3, 8'h99, 1'b0);
    @(negedge PCLK);
    PRESETn    = 1'b0;
    transfer   = 1'b1;
    READ_WRITE = 1'b0;
    busy_hi    = cyc;
    exp_q.delete();
    @(negedge PCLK);
    check("abort_reset_outputs", all_outputs(), 32'h0);
    PRESETn   = 1'b1;
    transfer  = 1'b0;
    last_rd   = '0;
    ready_cyc = cyc;
    busy_lo   = 1;
    busy_hi   = 0;
    issue(1'b0, 9'h022, 8'h11, 1, 8'h00, 1'b0);

    // Back-to-back write then read.
    issue(1'b0, 9'h133, 8'hC3, 0, 8'h00, 1'b0);
    issue(1'b1, 9'h004, 8'h00, 1, 8'h5E, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 5),
            DW'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    while (cyc < ready_cyc + 2) @(negedge PCLK);
    check("exp_q_drained", exp_q.size(), 0);
    check("slv_q_drained", slv_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
